// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - HI/LO instruction issue, hazard stall and MF read-back for the MDU
module mdu_issue_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 9
) (
  input  logic        Clk,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [3:0]  id_op,
  input  logic [31:0] id_rs,
  input  logic [31:0] id_rt,
  input  logic        ex_exception,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic [31:0] mdu_d1,
  output logic [31:0] mdu_d2,
  output logic [1:0]  mdu_op,
  output logic        mdu_start,
  output logic        mdu_madd,
  output logic        mdu_we,
  output logic        mdu_hilo,
  output logic        id_stall,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        div0
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2
  } state_t;

  localparam logic [3:0] L_MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] L_DIV_CNT = 4'(DIV_LAT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic        w_is_mdu;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_mt;
  logic        w_is_mf;
  logic        w_accept;

  assign mdu_d1 = id_rs;
  assign mdu_d2 = id_rt;

  // Decode op classes, hazard stall and the accept qualifier
  always_comb begin
    w_is_mdu = (id_op >= 4'd1) && (id_op <= 4'd9);
    w_is_mul = (id_op == 4'd1) || (id_op == 4'd2) || (id_op == 4'd5);
    w_is_div = (id_op == 4'd3) || (id_op == 4'd4);
    w_is_mt  = (id_op == 4'd6) || (id_op == 4'd7);
    w_is_mf  = (id_op == 4'd8) || (id_op == 4'd9);
    // Any HI/LO-class op must wait while our counter or the MDU itself reports activity
    id_stall = id_valid && w_is_mdu && ((r_state != S_IDLE) || mdu_busy);
    w_accept = id_valid && w_is_mdu && !id_stall && !ex_exception;
  end

  // MDU strobes, live only in the accept cycle
  always_comb begin
    mdu_start = w_accept && (w_is_div || id_op == 4'd1 || id_op == 4'd2);
    mdu_madd  = w_accept && (id_op == 4'd5);
    mdu_we    = w_accept && w_is_mt;
    mdu_hilo  = (id_op == 4'd6);
    case (id_op)
      4'd1:    mdu_op = 2'b00;
      4'd3:    mdu_op = 2'b10;
      4'd4:    mdu_op = 2'b11;
      default: mdu_op = 2'b01;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: load the latency on issue, count down while running
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_nxt = S_MUL_RUN;
          w_cnt_nxt   = L_MUL_CNT;
        end else if (w_accept && w_is_div) begin
          w_state_nxt = S_DIV_RUN;
          w_cnt_nxt   = L_DIV_CNT;
        end
      end
      S_MUL_RUN, S_DIV_RUN: begin
        // Exceptions do not abort a running operation; the count always continues
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Registered MF read port and divide-by-zero flag
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
      div0     <= 1'b0;
    end else begin
      rd_valid <= w_accept && w_is_mf;
      if (w_accept && w_is_mf) begin
        rd_data <= (id_op == 4'd8) ? mdu_hi : mdu_lo;
      end
      div0 <= w_accept && w_is_div && (id_rt == 32'd0);
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - randomized and directed self-checking bench for mdu_issue_ctrl
module tb_mdu_issue_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 9;

  logic        Clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [31:0] id_rs;
  logic [31:0] id_rt;
  logic        ex_exception;
  logic        mdu_busy;
  logic [31:0] mdu_hi;
  logic [31:0] mdu_lo;
  logic [31:0] mdu_d1;
  logic [31:0] mdu_d2;
  logic [1:0]  mdu_op;
  logic        mdu_start;
  logic        mdu_madd;
  logic        mdu_we;
  logic        mdu_hilo;
  logic        id_stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        div0;

  mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .Clk(Clk), .resetn(resetn), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .ex_exception(ex_exception), .mdu_busy(mdu_busy),
    .mdu_hi(mdu_hi), .mdu_lo(mdu_lo), .mdu_d1(mdu_d1), .mdu_d2(mdu_d2),
    .mdu_op(mdu_op), .mdu_start(mdu_start), .mdu_madd(mdu_madd), .mdu_we(mdu_we),
    .mdu_hilo(mdu_hilo), .id_stall(id_stall), .rd_valid(rd_valid), .rd_data(rd_data),
    .div0(div0)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the cycle index from which the MDU may accept again,
  // plus expected registered outputs for the next cycle.
  int          cyc = 0;
  int          free_at = 0;
  logic        e_rdv = 1'b0;
  logic [31:0] e_rdd = 32'd0;
  logic        e_div0 = 1'b0;
  int          busy_pct = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input logic exc, output logic stalled);
    logic               is_mdu, exp_stall, acc;
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        up;
    logic [31:0]        n_hi, n_lo;
    id_valid     = v;
    id_op        = op;
    id_rs        = rs;
    id_rt        = rt;
    ex_exception = exc;
    mdu_busy     = ($urandom_range(0, 99) < busy_pct);
    #1;
    is_mdu    = v && (op >= 4'd1) && (op <= 4'd9);
    exp_stall = is_mdu && ((cyc < free_at) || mdu_busy);
    acc       = is_mdu && !exp_stall && !exc;
    check("id_stall", 32'(id_stall), 32'(exp_stall));
    check("mdu_start", 32'(mdu_start), 32'(acc && op >= 4'd1 && op <= 4'd4));
    check("mdu_madd", 32'(mdu_madd), 32'(acc && op == 4'd5));
    check("mdu_we", 32'(mdu_we), 32'(acc && (op == 4'd6 || op == 4'd7)));
    check("mdu_d1", mdu_d1, rs);
    check("mdu_d2", mdu_d2, rt);
    if (acc && op >= 4'd1 && op <= 4'd4) check("mdu_op", 32'(mdu_op), 32'(op - 4'd1));
    if (acc && op == 4'd6) check("mdu_hilo_hi", 32'(mdu_hilo), 32'd1);
    if (acc && op == 4'd7) check("mdu_hilo_lo", 32'(mdu_hilo), 32'd0);

    // Expected read port / flag after the edge
    e_rdv  = acc && (op == 4'd8 || op == 4'd9);
    if (e_rdv) e_rdd = (op == 4'd8) ? mdu_hi : mdu_lo;
    e_div0 = acc && (op == 4'd3 || op == 4'd4) && (rt == 32'd0);
    if (acc && (op == 4'd1 || op == 4'd2 || op == 4'd5)) free_at = cyc + MUL_LAT + 1;
    if (acc && (op == 4'd3 || op == 4'd4)) free_at = cyc + DIV_LAT + 1;

    // Behavioural MDU played by the bench
    n_hi = mdu_hi;
    n_lo = mdu_lo;
    sa = {{32{rs[31]}}, rs};
    sb = {{32{rt[31]}}, rt};
    sp = sa * sb;
    up = {32'd0, rs} * {32'd0, rt};
    if (acc) begin
      case (op)
        4'd1: {n_hi, n_lo} = up;
        4'd2: {n_hi, n_lo} = sp;
        4'd3: if (rt != 0) begin n_lo = rs / rt; n_hi = rs % rt; end
        4'd4: if (rt != 0 && !(rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)) begin
                n_lo = 32'($signed(rs) / $signed(rt));
                n_hi = 32'($signed(rs) % $signed(rt));
              end
        4'd5: {n_hi, n_lo} = {mdu_hi, mdu_lo} + sp;
        4'd6: n_hi = rs;
        4'd7: n_lo = rs;
        default: ;
      endcase
    end
    @(posedge Clk);
    cyc++;
    #1;
    mdu_hi = n_hi;
    mdu_lo = n_lo;
    check("rd_valid", 32'(rd_valid), 32'(e_rdv));
    check("rd_data", rd_data, e_rdd);
    check("div0", 32'(div0), 32'(e_div0));
    stalled = exp_stall;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int nst);
    logic st;
    nst = 0;
    st  = 1'b1;
    for (int k = 0; k < 40 && st; k++) begin
      step(1'b1, op, rs, rt, 1'b0, st);
      if (st) nst++;
    end
    check("issue_done", 32'(st), 32'd0);
  endtask

  task automatic do_reset();
    id_valid     = 1'b1;
    id_op        = 4'd2;
    ex_exception = 1'b0;
    mdu_busy     = 1'b0;
    resetn       = 1'b0;
    #1;
    check("rst_id_stall", 32'(id_stall), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_div0", 32'(div0), 32'd0);
    @(negedge Clk);
    resetn = 1'b1;
    id_valid = 1'b0;
    @(posedge Clk);
    cyc++;
    #1;
    free_at = 0;
    e_rdv = 1'b0;
    e_rdd = 32'd0;
    e_div0 = 1'b0;
    mdu_hi = 32'd0;
    mdu_lo = 32'd0;
  endtask

  initial begin
    int          nst;
    logic        st;
    logic        cv, cx;
    logic [3:0]  cop;
    logic [31:0] crs, crt;

    resetn = 1'b0; id_valid = 1'b0; id_op = 4'd0; id_rs = 32'd0; id_rt = 32'd0;
    ex_exception = 1'b0; mdu_busy = 1'b0; mdu_hi = 32'd0; mdu_lo = 32'd0;
    #2;
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_div0", 32'(div0), 32'd0);
    check("reset_start", 32'(mdu_start), 32'd0);
    check("reset_stall", 32'(id_stall), 32'd0);
    @(negedge Clk);
    resetn = 1'b1;
    @(posedge Clk);
    cyc++;
    #1;

    // Mult then read
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, nst);
    check("mult_issue_stall", 32'(nst), 32'd0);
    issue(4'd9, 32'd0, 32'd0, nst);
    check("mult_stall_len", 32'(nst), 32'd4);
    check("mult_mflo", rd_data, 32'hFFFF_FFFA);
    issue(4'd8, 32'd0, 32'd0, nst);
    check("mult_mfhi", rd_data, 32'hFFFF_FFFF);

    // DIVU, then DIV by zero
    issue(4'd3, 32'd7, 32'd2, nst);
    issue(4'd8, 32'd0, 32'd0, nst);
    check("divu_stall_len", 32'(nst), 32'd9);
    check("divu_mfhi", rd_data, 32'd1);
    issue(4'd9, 32'd0, 32'd0, nst);
    check("divu_mflo", rd_data, 32'd3);
    issue(4'd4, 32'd5, 32'd0, nst);
    check("div0_pulse", 32'(div0), 32'd1);
    // NOP during busy
    step(1'b1, 4'd0, 32'd1, 32'd2, 1'b0, st);
    check("nop_no_stall", 32'(st), 32'd0);
    step(1'b1, 4'd12, 32'd1, 32'd2, 1'b0, st);
    check("nop12_no_stall", 32'(st), 32'd0);
    issue(4'd9, 32'd0, 32'd0, nst);
    check("div0_stall_len", 32'(nst), 32'd7);

    // MADD accumulation, back-to-back MT then MF
    issue(4'd6, 32'd0, 32'd0, nst);
    issue(4'd7, 32'd5, 32'd0, nst);
    issue(4'd9, 32'd0, 32'd0, nst);
    check("mt_mf_no_stall", 32'(nst), 32'd0);
    check("mt_mf_data", rd_data, 32'd5);
    issue(4'd5, 32'd2, 32'd3, nst);
    issue(4'd9, 32'd0, 32'd0, nst);
    check("madd_stall_len", 32'(nst), 32'd4);
    check("madd_mflo", rd_data, 32'd11);

    // Exception kill
    step(1'b1, 4'd2, 32'd9, 32'd9, 1'b1, st);
    issue(4'd9, 32'd0, 32'd0, nst);
    check("exc_no_stall", 32'(nst), 32'd0);
    check("exc_lo_kept", rd_data, 32'd11);

    // Reset mid-divide
    issue(4'd4, 32'd100, 32'd7, nst);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, st);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, st);
    do_reset();
    issue(4'd2, 32'd4, 32'd5, nst);
    check("post_reset_accept", 32'(nst), 32'd0);

    // Randomized phase against the model
    busy_pct = 10;
    st = 1'b0;
    cv = 1'b0; cop = 4'd0; crs = 32'd0; crt = 32'd0; cx = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        st = 1'b0;
      end
      if (!st) begin
        cv  = ($urandom_range(0, 3) != 0);
        cop = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) cop = 4'($urandom_range(8, 9));
        crs = $urandom;
        crt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      end
      cx = ($urandom_range(0, 7) == 0);
      step(cv, cop, crs, crt, cx, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
